seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the 4-bit ripple-carry adder. Processes a WIDTH-bit operation CHUNK bits per clock through a registered carry chain, trading latency for a short critical path. Start/busy/done handshake for use by datapath controllers. Add and subtract modes, with carry-out and signed-overflow flags.

---
 rtl/seq_chunk_adder_if.sv | 26 ++
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 tb/tb_seq_chunk_adder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done bus of the chunked adder/subtractor.
// The controller drives operands; the adder drives flags and result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock
// through a registered carry, with start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_ch;
  logic             c_msb;

  always_comb begin
    a_ch = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_ch = b_q[int'(idx_q)*CHUNK +: CHUNK];
    {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch}
                 + (CHUNK+1)'(carry_q);
    // carry into a sum bit is recoverable as a ^ b ^ s
    c_msb = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_ch;
        carry_d = c_ch;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          cout_d  = c_ch;
          ovf_d   = c_ch ^ c_msb;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: scoreboarded CHUNK=4 unit plus
// CHUNK=16 and CHUNK=1 instances for latency extremes.
module tb_seq_chunk_adder;
  localparam int NCH = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;

  seq_chunk_adder_if #(.WIDTH(16)) bus4 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus1 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic sub,
                                        input logic cin);
    logic [15:0] be;
    logic [16:0] full;
    logic        ov;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 17'(sub ? 1'b1 : cin);
    ov   = (a[15] == be[15]) && (full[15] != a[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  // Scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus4.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(bus4.sum), 32'(e.sum));
        chk("cout", 32'(bus4.cout), 32'(e.cout));
        chk("overflow", 32'(bus4.overflow), 32'(e.ovf));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin,
                       input logic [15:0] es,
                       input logic ec, input logic eo);
    bus4.a     = a;
    bus4.b     = b;
    bus4.sub   = sub;
    bus4.cin   = cin;
    bus4.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{es, ec, eo, cyc + NCH});
    bus4.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rs, rc;
    int          n, t0, l16, l1;
    logic [15:0] s16, s1;
    logic        c16, o1;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};

    bus4.start = 0; bus4.sub = 0; bus4.cin = 0; bus4.a = 0; bus4.b = 0;
    bus16.start = 0; bus16.sub = 0; bus16.cin = 0;
    bus16.a = 0; bus16.b = 0;
    bus1.start = 0; bus1.sub = 0; bus1.cin = 0;
    bus1.a = 0; bus1.b = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus4.busy), 0);
    chk("rst_done", 32'(bus4.done), 0);
    chk("rst_sum", 32'(bus4.sum), 0);
    chk("rst_cout", 32'(bus4.cout), 0);
    chk("rst_ovf", 32'(bus4.overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic op with busy window
    issue(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(bus4.busy), 1);
    end
    @(negedge clk);
    chk("busy_end", 32'(bus4.busy), 0);
    chk("done_pulse", 32'(bus4.done), 1);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
            vecs[i].s, vecs[i].co, vecs[i].ov);
      wait_done();
    end

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      m  = model(ra, rb, rs, rc);
      issue(ra, rb, rs, rc, m[15:0], m[17], m[16]);
      wait_done();
    end

    // Start and operand changes while busy are ignored
    issue(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a = 16'hFFFF;
    bus4.b = 16'hFFFF;
    bus4.sub = 1'b1;
    @(negedge clk);
    bus4.a = 16'h0000;
    bus4.b = 16'h0005;
    @(negedge clk);
    bus4.start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);

    // Start in the done cycle is accepted
    issue(16'h0F00, 16'h00F0, 0, 1, 16'h0FF1, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus4.done && n < 40);
    chk("b2b_done_seen", 32'(bus4.done), 1);
    issue(16'h4000, 16'h4000, 0, 0, 16'h8000, 0, 1);
    wait_done();

    // Async reset mid-operation
    issue(16'h0F0F, 16'h0101, 0, 0, 16'h1010, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus4.busy), 0);
    chk("arst_done", 32'(bus4.done), 0);
    chk("arst_sum", 32'(bus4.sum), 0);
    chk("arst_cout", 32'(bus4.cout), 0);
    chk("arst_ovf", 32'(bus4.overflow), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(16'h2222, 16'h1111, 1, 0, 16'h1111, 1, 0);
    wait_done();

    // Latency extremes: CHUNK=16 and CHUNK=1
    bus16.a = 16'hABCD; bus16.b = 16'h1234; bus16.start = 1'b1;
    bus1.a  = 16'hABCD; bus1.b  = 16'h1234; bus1.start  = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus16.start = 1'b0;
    bus1.start  = 1'b0;
    l16 = -1; l1 = -1;
    s16 = '0; s1 = '0; c16 = 1'bx; o1 = 1'bx;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus16.done && l16 < 0) begin
        l16 = cyc - t0; s16 = bus16.sum; c16 = bus16.cout;
      end
      if (bus1.done && l1 < 0) begin
        l1 = cyc - t0; s1 = bus1.sum; o1 = bus1.overflow;
      end
    end
    chk("c16_latency", 32'(l16), 32'd1);
    chk("c16_sum", 32'(s16), 32'hBE01);
    chk("c16_cout", 32'(c16), 32'd0);
    chk("c1_latency", 32'(l1), 32'd16);
    chk("c1_sum", 32'(s1), 32'hBE01);
    chk("c1_ovf", 32'(o1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
